// File: rtl/universal_reg.sv
// Multi-mode WIDTH-bit register: hold, load, shift left/right, toggle, count up/down, rotate.
// All outputs are registered; rst beats set beats en.
module universal_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             carry
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_TGL   = 3'b100,
        MODE_UP    = 3'b101,
        MODE_DOWN  = 3'b110,
        MODE_ROTL  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_out_q, ser_out_d;
    logic             carry_q, carry_d;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // NOTE: every variable gets its hold/default value first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        q_d       = q_q;
        ser_out_d = ser_out_q;
        carry_d   = 1'b0;

        if (set) begin
            q_d = SET_VAL;
        end else if (en) begin
            unique case (mode_sel)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = d;
                MODE_SHL: begin
                    q_d       = {q_q[WIDTH-2:0], ser_in};
                    ser_out_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d       = {ser_in, q_q[WIDTH-1:1]};
                    ser_out_d = q_q[0];
                end
                MODE_TGL: q_d = q_q ^ d;
                MODE_UP: begin
                    q_d     = q_q + ONE;
                    carry_d = (q_q == ALL_ONES);
                end
                MODE_DOWN: begin
                    q_d     = q_q - ONE;
                    carry_d = (q_q == ZERO);
                end
                MODE_ROTL: begin
                    q_d       = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    ser_out_d = q_q[WIDTH-1];
                end
                default: q_d = q_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RST_VAL;
            ser_out_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
            carry_q   <= carry_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_out_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_universal_reg.sv
// Scoreboard bench for universal_reg (WIDTH=8): directed scenarios then random ops,
// each checked against an arithmetic reference model.
module tb_universal_reg;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             set = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [WIDTH-1:0] d = '0;
    logic             ser_in = 1'b0;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             carry;

    universal_reg #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .set    (set),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .ser_in (ser_in),
        .q      (q),
        .ser_out(ser_out),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       so;
        logic       c;
        string      tag;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned mq  = 0;
    int unsigned mso = 0;
    int unsigned mc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register value treated as an integer 0..255.
    task automatic op(input logic r, input logic s, input logic e, input logic [2:0] m,
                      input logic [7:0] dv, input logic si, input string tag);
        @(negedge clk);
        rst = r; set = s; en = e; mode = m; d = dv; ser_in = si;
        mc = 0;
        if (r) begin
            mq = 0; mso = 0;
        end else if (s) begin
            mq = 255;
        end else if (e) begin
            case (m)
                3'd1: mq = int'(dv);
                3'd2: begin mso = mq / 128; mq = (mq * 2 + int'(si)) % 256; end
                3'd3: begin mso = mq % 2;   mq = mq / 2 + int'(si) * 128; end
                3'd4: mq = mq ^ int'(dv);
                3'd5: begin mc = (mq == 255) ? 1 : 0; mq = (mq + 1) % 256; end
                3'd6: begin mc = (mq == 0) ? 1 : 0;   mq = (mq + 255) % 256; end
                3'd7: begin mso = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
                default: ;
            endcase
        end
        sb.push_back('{q: 8'(mq), so: mso[0], c: mc[0], tag: tag});
    endtask

    // Monitor: every edge produces a registered result; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, " q"},       {24'b0, q},       {24'b0, e.q});
                check({e.tag, " ser_out"}, {31'b0, ser_out}, {31'b0, e.so});
                check({e.tag, " carry"},   {31'b0, carry},   {31'b0, e.c});
            end
        end
    end

    initial begin
        // Priority rst > set > en
        op(1, 1, 1, 3'd1, 8'hA5, 0, "prio_rst");
        op(0, 1, 1, 3'd1, 8'hA5, 0, "prio_set");
        op(0, 0, 1, 3'd1, 8'hA5, 0, "prio_load");
        // Count wrap up and down
        op(0, 0, 1, 3'd1, 8'hFE, 0, "ld_fe");
        repeat (3) op(0, 0, 1, 3'd5, 8'h00, 0, "cnt_up");
        op(0, 0, 1, 3'd1, 8'h01, 0, "ld_01");
        repeat (2) op(0, 0, 1, 3'd6, 8'h00, 0, "cnt_dn");
        // Shifts
        op(0, 0, 1, 3'd1, 8'h81, 0, "ld_81");
        op(0, 0, 1, 3'd2, 8'h00, 0, "shl");
        op(0, 0, 1, 3'd3, 8'h00, 1, "shr");
        // Toggle and rotate
        op(0, 0, 1, 3'd1, 8'h0F, 0, "ld_0f");
        op(0, 0, 1, 3'd4, 8'hFF, 0, "toggle");
        op(0, 0, 1, 3'd7, 8'h00, 0, "rotl");
        // Enable hold
        op(0, 0, 1, 3'd1, 8'h33, 0, "ld_33");
        repeat (3) op(0, 0, 0, 3'd5, 8'h00, 0, "en_hold");
        op(0, 0, 1, 3'd5, 8'h00, 0, "en_cnt");
        // Reset mid-count
        op(0, 0, 1, 3'd1, 8'h10, 0, "ld_10");
        op(0, 0, 1, 3'd5, 8'h00, 0, "mid_cnt");
        op(0, 0, 1, 3'd5, 8'h00, 0, "mid_cnt");
        op(1, 0, 1, 3'd5, 8'h00, 0, "mid_rst");
        op(0, 0, 1, 3'd5, 8'h00, 0, "post_rst");
        // Random mix
        for (int i = 0; i < 400; i++) begin
            op(($urandom_range(31) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
               3'($urandom_range(7)), 8'($urandom), 1'($urandom), "rand");
        end
        @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
